// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: shares one framer among NUM_MB mailboxes, lowest identifier first, one launch per idle window.
// Define CAN_TX_ONESHOT_EN for single-shot mode (no retry counter; any loss, error or timeout fails the mailbox).
module can_tx_scheduler #(
    parameter int NUM_MB      = 4,
    parameter int ID_W        = 11,
    parameter int RETRY_MAX   = 8,
    parameter int TIMEOUT_CYC = 4096,
    localparam int SEL_W      = (NUM_MB > 1) ? $clog2(NUM_MB) : 1,
    localparam int TMO_W      = $clog2(TIMEOUT_CYC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   interframePeriod,
    input  logic [NUM_MB-1:0]      txReq,
    input  logic [NUM_MB*ID_W-1:0] txId,
    input  logic                   txDone,
    input  logic                   txArbLost,
    input  logic                   txError,
    output logic                   txStart,
    output logic [SEL_W-1:0]       txSel,
    output logic [NUM_MB-1:0]      txAck,
    output logic [NUM_MB-1:0]      txFail,
    output logic                   busy,
    output logic [1:0]             dbgState
);
    // Framer handshake: txStart is a one-cycle launch; the framer answers with exactly one of
    // txDone/txArbLost/txError (one-cycle pulses), which only count while ACTIVE.
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_START, S_ACTIVE} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                armed_q, armed_d;
    logic                start_q, start_d;
    logic [NUM_MB-1:0]   ack_q, ack_d;
    logic [NUM_MB-1:0]   fail_q, fail_d;
    logic [NUM_MB-1:0]   sel_mask;
    logic                err_ev;
    logic                win_valid;
    logic [ID_W-1:0]     win_id;
    logic [SEL_W-1:0]    win_idx;
`ifndef CAN_TX_ONESHOT_EN
    logic [7:0]          retry_q, retry_d, retry_inc;

    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
`endif

    assign sel_mask = {{(NUM_MB-1){1'b0}}, 1'b1} << sel_q;

    // Strict less-than keeps the lowest index on identifier ties.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_idx   = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (txReq[i] && (!win_valid || (txId[i*ID_W +: ID_W] < win_id))) begin
                win_valid = 1'b1;
                win_id    = txId[i*ID_W +: ID_W];
                win_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;
        ack_d   = '0;
        fail_d  = '0;
        err_ev  = 1'b0;
`ifndef CAN_TX_ONESHOT_EN
        retry_d = retry_q;
`endif
        // Any non-idle bus cycle re-arms; the launch cycle disarms until the bus leaves idle.
        armed_d = !interframePeriod || (armed_q && !start_q);
        case (state_q)
            S_IDLE: begin
                if ((|txReq) && interframePeriod && armed_q) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (!win_valid) begin
                    state_d = S_IDLE;
                end else begin
                    sel_d   = win_idx;
                    start_d = 1'b1;
                    state_d = S_START;
`ifndef CAN_TX_ONESHOT_EN
                    if (win_idx != sel_q) retry_d = '0;
`endif
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                tmo_d  = tmo_q + 1'b1;
                err_ev = txError || (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`ifdef CAN_TX_ONESHOT_EN
                if (err_ev || txArbLost) begin
                    fail_d  = sel_mask;
                    state_d = S_IDLE;
                end else if (txDone) begin
                    ack_d   = sel_mask;
                    state_d = S_IDLE;
                end
`else
                if (err_ev) begin
                    state_d = S_IDLE;
                    if (retry_inc == 8'(RETRY_MAX)) begin
                        fail_d  = sel_mask;
                        retry_d = '0;
                    end else begin
                        retry_d = retry_inc;
                    end
                end else if (txArbLost) begin
                    state_d = S_IDLE;
                end else if (txDone) begin
                    ack_d   = sel_mask;
                    retry_d = '0;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            tmo_q   <= '0;
            armed_q <= 1'b1;
            start_q <= 1'b0;
            ack_q   <= '0;
            fail_q  <= '0;
`ifndef CAN_TX_ONESHOT_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            armed_q <= armed_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            fail_q  <= fail_d;
`ifndef CAN_TX_ONESHOT_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign txStart  = start_q;
    assign txSel    = sel_q;
    assign txAck    = ack_q;
    assign txFail   = fail_q;
    assign busy     = (state_q != S_IDLE);
    assign dbgState = state_q;
endmodule
